// File: rtl/nabp_pkg.sv
// nabp_pkg: shared sizes, FSM state type, FIFO entry type and pixel conversion for the NABP image writer
package nabp_pkg;
  localparam int NUM_PE = 4;
  localparam int ACC_W = 16;
  localparam int PIX_W = 8;
  localparam int ADDR_W = 12;
  localparam int PART_STRIDE = 1024;
  localparam int FIFO_DEPTH = 4;
  localparam int LANE_W = $clog2(NUM_PE);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic last;
    logic [NUM_PE*ACC_W-1:0] vals;
  } vec_t;
`ifdef NABP_IMAGE_WRITER_CLAMP_EN
  localparam logic [ACC_W-1:0] SAT_AT = ACC_W'((2**(ACC_W-1) - 1) >> (ACC_W - PIX_W));
  function automatic logic [PIX_W-1:0] conv(input logic [ACC_W-1:0] v);
    logic [ACC_W-1:0] s;
    s = ACC_W'($signed(v) >>> (ACC_W - PIX_W));
    return v[ACC_W-1] ? '0 : (s >= SAT_AT) ? '1 : s[PIX_W-1:0];
  endfunction
`else
  function automatic logic [PIX_W-1:0] conv(input logic [ACC_W-1:0] v);
    return PIX_W'(v >> (ACC_W - PIX_W));
  endfunction
`endif
endpackage

// File: rtl/nabp_image_writer_if.sv
// nabp_image_writer_if: PE result-vector input and image RAM write-out signals of the image writer
interface nabp_image_writer_if;
  import nabp_pkg::*;
  logic pe_valid;
  logic pe_ready;
  logic [ADDR_W-1:0] pe_base;
  logic [NUM_PE*ACC_W-1:0] pe_vals;
  logic pe_last;
  logic ir_we;
  logic ir_ready;
  logic [ADDR_W-1:0] ir_addr;
  logic [PIX_W-1:0] ir_data;
  logic done;
  modport master (
    output pe_valid, pe_base, pe_vals, pe_last, ir_ready,
    input pe_ready, ir_we, ir_addr, ir_data, done
  );
  modport slave (
    input pe_valid, pe_base, pe_vals, pe_last, ir_ready,
    output pe_ready, ir_we, ir_addr, ir_data, done
  );
endinterface

// File: rtl/nabp_image_writer_fifo.sv
// nabp_image_writer_fifo: synchronous FIFO of result vectors with extra-bit pointers and a registered full flag
module nabp_image_writer_fifo
  import nabp_pkg::*;
(
  input logic clk,
  input logic reset,
  input logic push,
  input logic pop,
  input vec_t din,
  output vec_t dout,
  output logic full,
  output logic empty
);
  localparam int PW = $clog2(FIFO_DEPTH);
  vec_t mem [FIFO_DEPTH];
  logic [PW:0] wptr, rptr, wptr_n, rptr_n;
  // next pointers, shared by the pointer registers and the full flag
  always_comb begin
    wptr_n = wptr + (PW+1)'(push);
    rptr_n = rptr + (PW+1)'(pop);
  end
  assign empty = wptr == rptr;
  assign dout = mem[rptr[PW-1:0]];
  // full is taken from the next pointers so it is a clean register; it is forced high through reset to hold off producers
  always_ff @(posedge clk) begin
    wptr <= reset ? '0 : wptr_n;
    rptr <= reset ? '0 : rptr_n;
    full <= reset || ((wptr_n ^ rptr_n) == {1'b1, {PW{1'b0}}});
    if (push) mem[wptr[PW-1:0]] <= din;
  end
endmodule

// File: rtl/nabp_image_writer.sv
// nabp_image_writer: buffers PE result vectors and serialises them into image RAM pixel writes (option NABP_IMAGE_WRITER_CLAMP_EN)
module nabp_image_writer
  import nabp_pkg::*;
(
  input logic clk,
  input logic reset,
  nabp_image_writer_if.slave bus
);
  state_t state, state_n;
  vec_t line, line_n, fifo_out, din;
  logic [LANE_W-1:0] lane, lane_n;
  logic full, empty, push, pop, acc;
  assign din = {bus.pe_base, bus.pe_last, bus.pe_vals};
  assign push = bus.pe_valid && !full;
  assign bus.pe_ready = !full;
  assign acc = bus.ir_we && bus.ir_ready;
  nabp_image_writer_fifo u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(din),
    .dout(fifo_out),
    .full(full),
    .empty(empty)
  );
  // state, line and lane registers
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : state_n;
    line <= reset ? '0 : line_n;
    lane <= reset ? '0 : lane_n;
  end
  // next state: walk the lanes of the held vector, chaining straight into the next queued one
  always_comb begin
    state_n = state;
    line_n = line;
    lane_n = lane;
    pop = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        line_n = fifo_out;
        lane_n = '0;
        state_n = WRITE;
      end
      WRITE: if (acc) begin
        if (lane != LANE_W'(NUM_PE-1)) lane_n = lane + LANE_W'(1);
        else if (line.last) state_n = DONE;
        else if (!empty) begin
          pop = 1'b1;
          line_n = fifo_out;
          lane_n = '0;
        end
        else state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
`ifdef NABP_IMAGE_WRITER_CLAMP_EN
  logic [PIX_W-1:0] pix;
  logic fill;
  // pixel stage fed from the next line/lane so it stays aligned with ir_addr; fill holds off the first write after an idle pop
  always_ff @(posedge clk) begin
    pix <= reset ? '0 : conv(line_n.vals[lane_n*ACC_W +: ACC_W]);
    fill <= !reset && state == IDLE && !empty;
  end
  // write-out drive
  always_comb begin
    bus.ir_we = state == WRITE && !fill;
    bus.ir_addr = line.base + ADDR_W'(PART_STRIDE * int'(lane));
    bus.ir_data = pix;
    bus.done = state == DONE;
  end
`else
  // write-out drive
  always_comb begin
    bus.ir_we = state == WRITE;
    bus.ir_addr = line.base + ADDR_W'(PART_STRIDE * int'(lane));
    bus.ir_data = conv(line.vals[lane*ACC_W +: ACC_W]);
    bus.done = state == DONE;
  end
`endif
endmodule
